// File: rtl/alu_issue_pkg.sv
// Shared encodings and the stage-1 record for the RV32I ALU issue/writeback stage.
package alu_issue_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      funct3;
    logic            control;
    logic            lt;
    logic            ltu;
    logic [4:0]      rd;
    logic            illegal;
  } issue_t;

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the instruction input, ALU drive/result and writeback output signals.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [2:0]      alu_operation;
  logic            alu_control;
  logic            alu_lt;
  logic            alu_ltu;
  logic [XLEN-1:0] alu_result;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_data;
  logic            out_we;
  logic            out_illegal;

  modport slave (
    input  flush, in_valid, in_instr, in_rs1_val, in_rs2_val, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_operation, alu_control, alu_lt, alu_ltu,
           out_valid, out_rd, out_data, out_we, out_illegal
  );

  modport master (
    output flush, in_valid, in_instr, in_rs1_val, in_rs2_val, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_operation, alu_control, alu_lt, alu_ltu,
           out_valid, out_rd, out_data, out_we, out_illegal
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational OP/OP-IMM decode: selects operand b, ALU controls, compare flags and legality.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  output issue_t          o_issue
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_b;
  logic            w_illegal;
  logic            w_control;
  logic [4:0]      w_unused_rs1_idx;

  assign w_opcode         = i_instr[6:0];
  assign w_f3             = i_instr[14:12];
  assign w_f7             = i_instr[31:25];
  assign w_imm            = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_unused_rs1_idx = i_instr[19:15];

  always_comb begin
    w_b       = i_rs2_val;
    w_illegal = 1'b1;
    w_control = 1'b0;
    if (w_opcode == OPC_OP) begin
      w_illegal = !((w_f7 == F7_BASE) ||
                    ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR))));
      w_control = ((w_f3 == F3_ADD) || (w_f3 == F3_SR)) && i_instr[30];
    end else if (w_opcode == OPC_OPIMM) begin
      // Only shifts carry an f7 field; ADDI with imm[10]=1 must not become a subtract.
      w_b       = w_imm;
      w_illegal = 1'b0;
      case (w_f3)
        F3_SLL: w_illegal = (w_f7 != F7_BASE);
        F3_SR: begin
          w_illegal = !((w_f7 == F7_BASE) || (w_f7 == F7_ALT));
          w_control = i_instr[30];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_issue         = '0;
    o_issue.a       = i_rs1_val;
    o_issue.b       = w_b;
    o_issue.funct3  = w_f3;
    o_issue.control = w_control;
    o_issue.lt      = $signed(i_rs1_val) < $signed(w_b);
    o_issue.ltu     = i_rs1_val < w_b;
    o_issue.rd      = i_instr[11:7];
    o_issue.illegal = w_illegal;
  end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue/writeback pipeline around an external combinational RV32I ALU.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  alu_issue_if.slave bus
);

  issue_t          w_dec;
  issue_t          r_s1;
  logic            r_s1_valid;
  logic            r_out_valid;
  logic            r_out_illegal;
  logic [4:0]      r_out_rd;
  logic [XLEN-1:0] r_out_data;
  logic            w_s2_free;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_capture;

  alu_issue_decode u_decode (
    .i_instr   (bus.in_instr),
    .i_rs1_val (bus.in_rs1_val),
    .i_rs2_val (bus.in_rs2_val),
    .o_issue   (w_dec)
  );

  assign w_s2_free  = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_free;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_capture  = r_s1_valid && w_s2_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1          <= '0;
      r_s1_valid    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_illegal <= 1'b0;
      r_out_rd      <= '0;
      r_out_data    <= '0;
    end else if (bus.flush) begin
      // Data registers keep stale contents; only the valid bits matter.
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1       <= w_dec;
        r_s1_valid <= 1'b1;
      end else if (w_capture) begin
        r_s1_valid <= 1'b0;
      end
      if (w_capture) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= r_s1.illegal ? '0 : bus.alu_result;
        r_out_rd      <= r_s1.illegal ? 5'd0 : r_s1.rd;
        r_out_illegal <= r_s1.illegal;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.alu_a         = r_s1.a;
  assign bus.alu_b         = r_s1.b;
  assign bus.alu_operation = r_s1.funct3;
  assign bus.alu_control   = r_s1.control;
  assign bus.alu_lt        = r_s1.lt;
  assign bus.alu_ltu       = r_s1.ltu;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_rd        = r_out_rd;
  assign bus.out_data      = r_out_data;
  assign bus.out_illegal   = r_out_illegal;
  assign bus.out_we        = r_out_valid && !r_out_illegal && (r_out_rd != 5'd0);

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with an external ALU model and an in-order result scoreboard.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_if bus();

  alu_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External combinational ALU driven by the stage-1 outputs.
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_operation)
      3'd0: bus.alu_result = bus.alu_control ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;
      3'd1: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      3'd2: bus.alu_result = {31'd0, bus.alu_lt};
      3'd3: bus.alu_result = {31'd0, bus.alu_ltu};
      3'd4: bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'd5: bus.alu_result = bus.alu_control ? $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0])
                                             : bus.alu_a >> bus.alu_b[4:0];
      3'd6: bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = bus.alu_a & bus.alu_b;
    endcase
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [2:0] f3, logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  // Architectural reference for one instruction's writeback.
  function automatic exp_t model(logic [31:0] instr, logic [31:0] rs1, logic [31:0] rs2);
    exp_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] b;
    logic [31:0] r;
    logic        legal;
    logic        alt;
    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    b = rs2; legal = 1'b0; alt = 1'b0; r = '0;
    if (opc == 7'b0110011) begin
      legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      alt   = (f7 == 7'h20);
    end else if (opc == 7'b0010011) begin
      b = {{20{instr[31]}}, instr[31:20]};
      if (f3 == 3'd1)      legal = (f7 == 7'h00);
      else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      else                 legal = 1'b1;
      alt = (f3 == 3'd5) && (f7 == 7'h20);
    end
    case (f3)
      3'd0: r = alt ? rs1 - b : rs1 + b;
      3'd1: r = rs1 << b[4:0];
      3'd2: r = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (rs1 < b) ? 32'd1 : 32'd0;
      3'd4: r = rs1 ^ b;
      3'd5: r = alt ? $unsigned($signed(rs1) >>> b[4:0]) : rs1 >> b[4:0];
      3'd6: r = rs1 | b;
      default: r = rs1 & b;
    endcase
    e.illegal = !legal;
    e.rd      = legal ? instr[11:7] : 5'd0;
    e.data    = legal ? r : 32'd0;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(logic [31:0] instr, logic [31:0] rs1, logic [31:0] rs2);
    bus.in_valid   = 1'b1;
    bus.in_instr   = instr;
    bus.in_rs1_val = rs1;
    bus.in_rs2_val = rs2;
  endtask

  // Sample both handshakes mid-cycle, then advance to just past the next rising edge.
  task automatic tick(output bit acc);
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (bus.flush) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL sb_underflow: observed unexpected entry rd %0d expected none", bus.out_rd);
        end else begin
          e = sb.pop_front();
          chk("sb_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
          chk("sb_data", bus.out_data, e.data);
          chk("sb_illegal", {31'd0, bus.out_illegal}, {31'd0, e.illegal});
          chk("sb_we", {31'd0, bus.out_we}, {31'd0, !e.illegal && (e.rd != 5'd0)});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.in_instr, bus.in_rs1_val, bus.in_rs2_val));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    bit a;
    tick(a);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    bit acc;
    int k;
    int pop0;
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0;
    bus.in_rs1_val = '0; bus.in_rs2_val = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);

    // ADD then SUB
    offer(enc_r(7'h00, 3'd0, 5'd3, 7'b0110011), 32'd5, 32'd7);
    step();
    chk("add_ctrl", {31'd0, bus.alu_control}, 32'd0);
    chk("add_alu_b", bus.alu_b, 32'd7);
    chk("add_out_valid_early", {31'd0, bus.out_valid}, 32'd0);
    offer(enc_r(7'h20, 3'd0, 5'd4, 7'b0110011), 32'd5, 32'd7);
    step();
    bus.in_valid = 1'b0;
    chk("sub_ctrl", {31'd0, bus.alu_control}, 32'd1);
    chk("add_data", bus.out_data, 32'd12);
    chk("add_rd", {27'd0, bus.out_rd}, 32'd3);
    chk("add_we", {31'd0, bus.out_we}, 32'd1);
    step();
    chk("sub_data", bus.out_data, 32'hFFFF_FFFE);
    chk("sub_rd", {27'd0, bus.out_rd}, 32'd4);
    step();
    chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // SLTI / SLTIU against imm -1
    offer(enc_i(12'hFFF, 3'd2, 5'd5), 32'd1, 32'd0);
    step();
    chk("slti_lt", {31'd0, bus.alu_lt}, 32'd0);
    chk("slti_b", bus.alu_b, 32'hFFFF_FFFF);
    offer(enc_i(12'hFFF, 3'd3, 5'd6), 32'd1, 32'd0);
    step();
    bus.in_valid = 1'b0;
    chk("sltiu_ltu", {31'd0, bus.alu_ltu}, 32'd1);
    chk("slti_data", bus.out_data, 32'd0);
    step();
    chk("sltiu_data", bus.out_data, 32'd1);

    // SRAI vs SRLI
    offer(enc_i({7'b0100000, 5'd4}, 3'd5, 5'd7), 32'h8000_0000, 32'd0);
    step();
    chk("srai_ctrl", {31'd0, bus.alu_control}, 32'd1);
    offer(enc_i({7'b0000000, 5'd4}, 3'd5, 5'd8), 32'h8000_0000, 32'd0);
    step();
    bus.in_valid = 1'b0;
    chk("srai_data", bus.out_data, 32'hF800_0000);
    step();
    chk("srli_data", bus.out_data, 32'h0800_0000);

    // Illegal encodings, ADDI with imm[10]=1, write to x0
    offer(enc_r(7'h00, 3'd0, 5'd9, 7'b0000011), 32'd5, 32'd7);
    step();
    offer(enc_r(7'h01, 3'd0, 5'd10, 7'b0110011), 32'd5, 32'd7);
    step();
    chk("ill_flag", {31'd0, bus.out_illegal}, 32'd1);
    chk("ill_data", bus.out_data, 32'd0);
    chk("ill_rd", {27'd0, bus.out_rd}, 32'd0);
    chk("ill_we", {31'd0, bus.out_we}, 32'd0);
    offer(enc_i(12'h400, 3'd0, 5'd11), 32'd1, 32'd0);
    step();
    chk("addi_ctrl", {31'd0, bus.alu_control}, 32'd0);
    chk("ill2_flag", {31'd0, bus.out_illegal}, 32'd1);
    offer(enc_r(7'h20, 3'd1, 5'd12, 7'b0110011), 32'd5, 32'd7);
    step();
    chk("addi_data", bus.out_data, 32'h0000_0401);
    offer(enc_r(7'h00, 3'd4, 5'd0, 7'b0110011), 32'hF0F0_0000, 32'h0F0F_0000);
    step();
    chk("sll_alt_ill", {31'd0, bus.out_illegal}, 32'd1);
    bus.in_valid = 1'b0;
    step();
    chk("x0_we", {31'd0, bus.out_we}, 32'd0);
    drain();

    // Backpressure: four adds, consumer stalled for three cycles
    pop0 = n_pop;
    bus.out_ready = 1'b0;
    k = 0;
    offer(enc_r(7'h00, 3'd0, 5'd12, 7'b0110011), 32'd0, 32'd100);
    tick(acc); if (acc) k++;
    offer(enc_r(7'h00, 3'd0, 5'(12 + k), 7'b0110011), 32'(k), 32'd100);
    tick(acc); if (acc) k++;
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_hold_data0", bus.out_data, 32'd100);
    offer(enc_r(7'h00, 3'd0, 5'(12 + k), 7'b0110011), 32'(k), 32'd100);
    tick(acc); if (acc) k++;
    chk("bp_accepts", k, 2);
    chk("bp_hold_data1", bus.out_data, 32'd100);
    chk("bp_hold_rd", {27'd0, bus.out_rd}, 32'd12);
    chk("bp_hold_alu_a", bus.alu_a, 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && k < 4; i++) begin
      tick(acc);
      if (acc) begin
        k++;
        if (k < 4) offer(enc_r(7'h00, 3'd0, 5'(12 + k), 7'b0110011), 32'(k), 32'd100);
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("bp_all_accepted", k, 4);
    drain();
    chk("bp_pops", n_pop - pop0, 4);

    // Flush with both stages full and a new instruction offered
    bus.out_ready = 1'b0;
    offer(enc_r(7'h00, 3'd0, 5'd20, 7'b0110011), 32'd1, 32'd1);
    step();
    offer(enc_r(7'h00, 3'd0, 5'd21, 7'b0110011), 32'd2, 32'd2);
    step();
    offer(enc_r(7'h00, 3'd0, 5'd22, 7'b0110011), 32'd3, 32'd3);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    pop0 = n_pop;
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("flush_dropped", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_pops", n_pop - pop0, 0);

    // Asynchronous reset in the middle of a stream
    offer(enc_r(7'h00, 3'd0, 5'd23, 7'b0110011), 32'd9, 32'd1);
    step();
    step();
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_out_data", bus.out_data, 32'd0);
    chk("arst_alu_a", bus.alu_a, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    sb.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    offer(enc_r(7'h00, 3'd0, 5'd24, 7'b0110011), 32'd3, 32'd4);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("post_rst_data", bus.out_data, 32'd7);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
